// File: rtl/dma_cmd_scheduler.sv
// Round-robin arbiter sharing one DMA command channel between NUM_REQ requesters.
// Grants one command at a time, pulses the core start and waits for done or a watchdog.
module dma_cmd_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*16-1:0]        req_addr_high,
    input  logic [NUM_REQ*16-1:0]        req_addr_low,
    input  logic [NUM_REQ*6-1:0]         req_length,
    input  logic                         CoreSystem_Master_Done,
    output logic                         o_CoreSystemStart,
    output logic [15:0]                  o_RCC_DMA_ADDR_HIGH,
    output logic [15:0]                  o_RCC_DMA_ADDR_LOW,
    output logic [5:0]                   o_RCC_BUFFER_LENGTH,
    output logic [$clog2(NUM_REQ)-1:0]   o_grant_id,
    output logic                         o_busy,
    output logic                         o_len_err,
    output logic                         o_timeout
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      hi_q, hi_d;
    logic [15:0]      lo_q, lo_d;
    logic [5:0]       len_q, len_d;
    logic [IDW-1:0]   gid_q, gid_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             len_err_q, len_err_d;
    logic             timeout_q, timeout_d;

    logic             found_s;
    logic [IDW-1:0]   win_s;
    logic [IDW-1:0]   nxt_ptr_s;
    logic [15:0]      sel_hi_s;
    logic [15:0]      sel_lo_s;
    logic [5:0]       sel_len_s;

    // Round-robin search: first valid requester starting at rr_q, wrapping modulo NUM_REQ.
    always_comb begin : winner_search
        logic [IDW-1:0] idx_v;
        found_s = 1'b0;
        win_s   = '0;
        idx_v   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v   = IDW'((int'(rr_q) + k) % NUM_REQ);
            win_s   = (!found_s && req_valid[idx_v]) ? idx_v : win_s;
            found_s = found_s | req_valid[idx_v];
        end
    end

    // Winner payload and the pointer value that follows it.
    always_comb begin
        sel_hi_s  = req_addr_high[16*win_s +: 16];
        sel_lo_s  = req_addr_low[16*win_s +: 16];
        sel_len_s = req_length[6*win_s +: 6];
        nxt_ptr_s = (win_s == IDW'(NUM_REQ - 1)) ? '0 : win_s + IDW'(1);
    end

    // Grant is only offered while idle, one-hot at the winner.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && found_s) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        len_d     = len_q;
        gid_d     = gid_q;
        len_err_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (found_s) begin
                    rr_d = nxt_ptr_s;
                    if (sel_len_s == 6'd0) begin
                        len_err_d = 1'b1;
                    end else begin
                        hi_d    = sel_hi_s;
                        lo_d    = sel_lo_s;
                        len_d   = sel_len_s;
                        gid_d   = win_s;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    rr_d = rr_q;
                end
            end
            ST_ISSUE: begin
                // Counting the ISSUE edge lets expiry land TIMEOUT_CYCLES-1 edges into WAIT.
                cnt_d   = cnt_q + CW'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (CoreSystem_Master_Done) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        start_d = (state_d == ST_ISSUE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            cnt_q     <= '0;
            hi_q      <= 16'd0;
            lo_q      <= 16'd0;
            len_q     <= 6'd0;
            gid_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            len_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            len_q     <= len_d;
            gid_q     <= gid_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            len_err_q <= len_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_CoreSystemStart   = start_q;
    assign o_RCC_DMA_ADDR_HIGH = hi_q;
    assign o_RCC_DMA_ADDR_LOW  = lo_q;
    assign o_RCC_BUFFER_LENGTH = len_q;
    assign o_grant_id          = gid_q;
    assign o_busy              = busy_q;
    assign o_len_err           = len_err_q;
    assign o_timeout           = timeout_q;

endmodule

// File: tb/tb_dma_cmd_scheduler.sv
// Scoreboard bench for dma_cmd_scheduler: a transaction-level model predicts grants,
// start/len_err/timeout pulses; a monitor compares them as the DUT produces them.
module tb_dma_cmd_scheduler;

    localparam int N   = 4;
    localparam int TC  = 8;
    localparam int IDW = 2;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*16-1:0]   req_addr_high;
    logic [N*16-1:0]   req_addr_low;
    logic [N*6-1:0]    req_length;
    logic              CoreSystem_Master_Done;
    logic              o_CoreSystemStart;
    logic [15:0]       o_RCC_DMA_ADDR_HIGH;
    logic [15:0]       o_RCC_DMA_ADDR_LOW;
    logic [5:0]        o_RCC_BUFFER_LENGTH;
    logic [IDW-1:0]    o_grant_id;
    logic              o_busy;
    logic              o_len_err;
    logic              o_timeout;

    always #5 HCLK = ~HCLK;

    dma_cmd_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TC)) dut (
        .HCLK                   (HCLK),
        .HRESET                 (HRESET),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_addr_high          (req_addr_high),
        .req_addr_low           (req_addr_low),
        .req_length             (req_length),
        .CoreSystem_Master_Done (CoreSystem_Master_Done),
        .o_CoreSystemStart      (o_CoreSystemStart),
        .o_RCC_DMA_ADDR_HIGH    (o_RCC_DMA_ADDR_HIGH),
        .o_RCC_DMA_ADDR_LOW     (o_RCC_DMA_ADDR_LOW),
        .o_RCC_BUFFER_LENGTH    (o_RCC_BUFFER_LENGTH),
        .o_grant_id             (o_grant_id),
        .o_busy                 (o_busy),
        .o_len_err              (o_len_err),
        .o_timeout              (o_timeout)
    );

    typedef struct {
        int          e;
        int          id;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [5:0]  len;
    } start_t;

    int     total = 0;
    int     bad   = 0;
    int     edge_cnt = 0;
    bit     mon_en = 1'b0;

    start_t start_q[$];
    int     lenerr_q[$];
    int     to_q[$];
    bit     done_sched[int];

    // Reference model state (transaction level: who is waiting, when the channel frees up)
    int          rr_m;
    int          free_edge;
    int          acc_edge;
    logic [15:0] last_hi;
    logic [15:0] last_lo;
    logic [5:0]  last_len;
    int          last_id;
    bit          pend[N];
    logic [15:0] p_hi[N];
    logic [15:0] p_lo[N];
    logic [5:0]  p_len[N];
    bit          gen_en;
    bit          refill_all;
    int          done_mode;

    always @(posedge HCLK) edge_cnt <= edge_cnt + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void miss(string name, int e);
        total++;
        bad++;
        $display("FAIL %s: no pulse seen, expected one after edge %0d", name, e);
    endfunction

    function automatic void model_reset();
        rr_m      = 0;
        free_edge = 0;
        acc_edge  = -1;
        last_hi   = 16'd0;
        last_lo   = 16'd0;
        last_len  = 6'd0;
        last_id   = 0;
        start_q.delete();
        lenerr_q.delete();
        to_q.delete();
        done_sched.delete();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        req_valid              = '0;
        CoreSystem_Master_Done = 1'b0;
    endfunction

    function automatic void new_cmd(int i, bit allow_zero);
        pend[i]  = 1'b1;
        p_hi[i]  = 16'($urandom);
        p_lo[i]  = 16'($urandom);
        p_len[i] = (allow_zero && $urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    endfunction

    function automatic void set_cmd(int i, logic [15:0] hi, logic [15:0] lo, logic [5:0] len);
        pend[i]  = 1'b1;
        p_hi[i]  = hi;
        p_lo[i]  = lo;
        p_len[i] = len;
    endfunction

    // Plan the done response for a command accepted at edge n; predict timeout if none lands in WAIT.
    function automatic void plan_done(int n);
        int d;
        d = -1;
        case (done_mode)
            0: begin
                if ($urandom_range(0, 3) != 0) d = n + 2 + int'($urandom_range(0, TC));
                if ($urandom_range(0, 3) == 0) done_sched[n + 1] = 1'b1;
            end
            1: d = n + 4;
            3: d = n + TC;
            4: done_sched[n + 1] = 1'b1;
            default: d = -1;
        endcase
        if (d >= 0) done_sched[d] = 1'b1;
        if (d >= n + 2 && d <= n + TC) begin
            free_edge = d + 1;
        end else begin
            free_edge = n + TC + 1;
            to_q.push_back(n + TC);
        end
    endfunction

    // One stimulus cycle: drive inputs for the coming edge and record what must follow.
    task automatic drive_cycle();
        int           n;
        int           w;
        logic [N-1:0] v;
        logic [N-1:0] exp_ready;
        logic [N*16-1:0] hv;
        logic [N*16-1:0] lv;
        logic [N*6-1:0]  nv;
        start_t       s;
        @(negedge HCLK);
        n = edge_cnt;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && refill_all) new_cmd(i, 1'b0);
            else if (!pend[i] && gen_en && $urandom_range(0, 3) == 0) new_cmd(i, 1'b1);
            v[i] = pend[i] && (!gen_en || $urandom_range(0, 7) != 0);
            hv[16*i +: 16] = p_hi[i];
            lv[16*i +: 16] = p_lo[i];
            nv[6*i +: 6]   = p_len[i];
        end
        exp_ready = '0;
        w = -1;
        if (n >= free_edge) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && v[(rr_m + k) % N]) w = (rr_m + k) % N;
            end
        end
        if (w >= 0) begin
            exp_ready[w] = 1'b1;
            pend[w] = 1'b0;
            rr_m = (w + 1) % N;
            if (p_len[w] == 6'd0) begin
                lenerr_q.push_back(n);
                free_edge = n + 1;
            end else begin
                s.e = n; s.id = w; s.hi = p_hi[w]; s.lo = p_lo[w]; s.len = p_len[w];
                start_q.push_back(s);
                last_hi = p_hi[w]; last_lo = p_lo[w]; last_len = p_len[w]; last_id = w;
                acc_edge = n;
                plan_done(n);
            end
        end
        req_valid              = v;
        req_addr_high          = hv;
        req_addr_low           = lv;
        req_length             = nv;
        CoreSystem_Master_Done = done_sched.exists(n);
        #1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
    endtask

    // Monitor: after each edge compare held outputs and pop pulse expectations.
    initial begin : monitor
        int     k;
        bit     bexp;
        start_t s;
        forever begin
            @(posedge HCLK);
            #1;
            if (mon_en) begin
                k = edge_cnt - 1;
                bexp = (acc_edge >= 0) && (k >= acc_edge) && (k < free_edge - 1);
                check("busy", 64'(o_busy), 64'(bexp));
                check("rcc_high", 64'(o_RCC_DMA_ADDR_HIGH), 64'(last_hi));
                check("rcc_low", 64'(o_RCC_DMA_ADDR_LOW), 64'(last_lo));
                check("rcc_len", 64'(o_RCC_BUFFER_LENGTH), 64'(last_len));
                check("grant_id", 64'(o_grant_id), 64'(last_id));
                while (start_q.size() > 0 && start_q[0].e < k) miss("start", start_q.pop_front().e);
                if (o_CoreSystemStart) begin
                    if (start_q.size() > 0 && start_q[0].e == k) begin
                        s = start_q.pop_front();
                        check("start_id", 64'(o_grant_id), 64'(s.id));
                        check("start_cmd", {28'd0, o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW, o_RCC_BUFFER_LENGTH},
                              {28'd0, s.hi, s.lo, s.len});
                    end else begin
                        check("start_unexpected", 64'd1, 64'd0);
                    end
                end
                while (lenerr_q.size() > 0 && lenerr_q[0] < k) miss("len_err", lenerr_q.pop_front());
                if (o_len_err) begin
                    if (lenerr_q.size() > 0 && lenerr_q[0] == k) begin
                        check("len_err_edge", 64'(k), 64'(lenerr_q.pop_front()));
                    end else begin
                        check("len_err_unexpected", 64'd1, 64'd0);
                    end
                end
                while (to_q.size() > 0 && to_q[0] < k) miss("timeout", to_q.pop_front());
                if (o_timeout) begin
                    if (to_q.size() > 0 && to_q[0] == k) begin
                        check("timeout_edge", 64'(k), 64'(to_q.pop_front()));
                    end else begin
                        check("timeout_unexpected", 64'd1, 64'd0);
                    end
                end
            end
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, "_start"}, 64'(o_CoreSystemStart), 64'd0);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_rcc"}, {28'd0, o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW, o_RCC_BUFFER_LENGTH}, 64'd0);
        check({tag, "_gid"}, 64'(o_grant_id), 64'd0);
        check({tag, "_pulses"}, {62'd0, o_len_err, o_timeout}, 64'd0);
    endtask

    initial begin
        HRESET        = 1'b1;
        req_addr_high = '0;
        req_addr_low  = '0;
        req_length    = '0;
        gen_en        = 1'b0;
        refill_all    = 1'b0;
        done_mode     = 2;
        for (int i = 0; i < N; i++) begin
            p_hi[i] = 16'd0; p_lo[i] = 16'd0; p_len[i] = 6'd0;
        end
        model_reset();
        repeat (3) @(posedge HCLK);
        #1;
        check_all_zero("reset");
        check("reset_ready", 64'(req_ready), 64'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
        mon_en = 1'b1;

        // Fairness: all four always valid, done 3 cycles after each start
        done_mode  = 1;
        refill_all = 1'b1;
        repeat (25) drive_cycle();
        refill_all = 1'b0;
        repeat (20) drive_cycle();

        // Single request from requester 2
        set_cmd(2, 16'h1234, 16'hABCD, 6'd16);
        repeat (8) drive_cycle();

        // Zero-length from requester 1, then 0 and 2 compete
        set_cmd(1, 16'h5555, 16'h6666, 6'd0);
        drive_cycle();
        set_cmd(0, 16'h0A0A, 16'h0B0B, 6'd5);
        set_cmd(2, 16'h2222, 16'h3333, 6'd7);
        repeat (14) drive_cycle();

        // Watchdog: no done, done exactly at expiry, done only during ISSUE
        done_mode = 2;
        set_cmd(0, 16'hDEAD, 16'hBEEF, 6'd1);
        repeat (TC + 6) drive_cycle();
        done_mode = 3;
        set_cmd(1, 16'hCAFE, 16'hF00D, 6'd63);
        repeat (TC + 6) drive_cycle();
        done_mode = 4;
        set_cmd(2, 16'h0001, 16'h0002, 6'd3);
        repeat (TC + 6) drive_cycle();

        // Reset in the middle of WAIT, then requester 3 gets a fresh grant
        done_mode = 2;
        set_cmd(0, 16'h7777, 16'h8888, 6'd9);
        repeat (4) drive_cycle();
        @(posedge HCLK);
        #3;
        mon_en = 1'b0;
        HRESET = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge HCLK);
        model_reset();
        @(negedge HCLK);
        HRESET = 1'b0;
        mon_en = 1'b1;
        done_mode = 1;
        set_cmd(3, 16'h3333, 16'h4444, 6'd12);
        repeat (8) drive_cycle();

        // Randomized traffic
        gen_en    = 1'b1;
        done_mode = 0;
        repeat (1500) drive_cycle();
        gen_en = 1'b0;
        repeat (60) drive_cycle();

        check("start_q_drained", 64'(start_q.size()), 64'd0);
        check("lenerr_q_drained", 64'(lenerr_q.size()), 64'd0);
        check("timeout_q_drained", 64'(to_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
